// File: rtl/dmem_req_pkg.sv
// Shared definitions for the data-side request controller.
package dmem_req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_CNT_W   = 16;

    // A request is illegal if it asks for both load and store, or is not halfword aligned.
    function automatic logic req_illegal(input logic rd, input logic wr, input logic addr_lsb);
        return (rd & wr) | addr_lsb;
    endfunction

endpackage

// File: rtl/dmem_req_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_cnt
    import dmem_req_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count up on i_inc, stick at all-ones, clear on i_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_req_ctrl.sv
// Request controller between the MEM pipeline stage and mem_system.
// Screens illegal requests, holds the memory interface stable until Done,
// returns a one-cycle response, aborts on watchdog expiry and keeps stats.
module dmem_req_ctrl
    import dmem_req_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_rd,
    input  logic             req_wr,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wdata,
    output logic             pipe_stall,
    output logic             resp_valid,
    output logic [15:0]      resp_rdata,
    output logic             resp_err,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_done,
    input  logic             mem_stall,
    input  logic             mem_hit,
    input  logic             mem_err,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             timeout_flag
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic        r_resp_valid;
    logic [15:0] r_resp_rdata;
    logic        r_resp_err;
    logic [15:0] r_timer;
    logic        r_timeout_flag;

    state_t      w_state_nxt;
    logic [15:0] w_mem_addr_nxt;
    logic [15:0] w_mem_wdata_nxt;
    logic        w_mem_rd_nxt;
    logic        w_mem_wr_nxt;
    logic        w_resp_valid_nxt;
    logic [15:0] w_resp_rdata_nxt;
    logic        w_resp_err_nxt;
    logic [15:0] w_timer_nxt;
    logic        w_hit_inc;
    logic        w_miss_inc;
    logic        w_timeout_set;
    logic        w_stall;

    // Done is authoritative for sequencing; Stall is informational only.
    logic        w_unused_mem_stall;
    assign w_unused_mem_stall = mem_stall;

    // State register and all registered interface outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_mem_addr   <= 16'h0000;
            r_mem_wdata  <= 16'h0000;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 16'h0000;
            r_resp_err   <= 1'b0;
            r_timer      <= 16'h0000;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_rd     <= w_mem_rd_nxt;
            r_mem_wr     <= w_mem_wr_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_timer      <= w_timer_nxt;
        end
    end

    // Next-state, next-output and statistic-event decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_rd_nxt     = r_mem_rd;
        w_mem_wr_nxt     = r_mem_wr;
        w_resp_valid_nxt = 1'b0;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;
        w_timer_nxt      = r_timer;
        w_hit_inc        = 1'b0;
        w_miss_inc       = 1'b0;
        w_timeout_set    = 1'b0;
        w_stall          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_rd || req_wr) begin
                    w_stall = 1'b1;
                    if (req_illegal(req_rd, req_wr, req_addr[0])) begin
                        w_state_nxt      = ST_RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_rdata_nxt = 16'h0000;
                        w_resp_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt     = ST_BUSY;
                        w_mem_addr_nxt  = req_addr;
                        w_mem_wdata_nxt = req_wdata;
                        w_mem_rd_nxt    = req_rd;
                        w_mem_wr_nxt    = req_wr;
                        w_timer_nxt     = 16'h0000;
                    end
                end else begin
                    w_stall = 1'b0;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (mem_done) begin
                    w_state_nxt      = ST_RESP;
                    w_mem_rd_nxt     = 1'b0;
                    w_mem_wr_nxt     = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = r_mem_rd ? mem_rdata : 16'h0000;
                    w_resp_err_nxt   = mem_err;
                    if (!mem_err) begin
                        w_hit_inc  = mem_hit;
                        w_miss_inc = ~mem_hit;
                    end else begin
                        w_hit_inc  = 1'b0;
                        w_miss_inc = 1'b0;
                    end
                end else if (mem_err || (r_timer == TIMER_LAST)) begin
                    // Error without Done, or watchdog expiry: abort the access.
                    w_state_nxt      = ST_RESP;
                    w_mem_rd_nxt     = 1'b0;
                    w_mem_wr_nxt     = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = 16'h0000;
                    w_resp_err_nxt   = 1'b1;
                    w_timeout_set    = ~mem_err;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_mem_rd_nxt = 1'b0;
                w_mem_wr_nxt = 1'b0;
            end
        endcase
    end

    // Sticky watchdog indicator; clear has priority over a new abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout_flag <= 1'b0;
        end else if (stat_clr) begin
            r_timeout_flag <= 1'b0;
        end else if (w_timeout_set) begin
            r_timeout_flag <= 1'b1;
        end else begin
            r_timeout_flag <= r_timeout_flag;
        end
    end

    sat_cnt #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_hit_inc),
        .i_clr (stat_clr),
        .o_cnt (hit_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_miss_inc),
        .i_clr (stat_clr),
        .o_cnt (miss_cnt)
    );

    // Stall drops as soon as reset is applied, not at the next edge.
    assign pipe_stall   = w_stall & ~rst;
    assign resp_valid   = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;
    assign resp_err     = r_resp_err;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_rd       = r_mem_rd;
    assign mem_wr       = r_mem_wr;
    assign timeout_flag = r_timeout_flag;

endmodule
